// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the 5-port mesh router switch allocator:
// port indices, flit type codes, select encoding and FSM state type.
package switch_allocator_pkg;

    // Number of input/output ports and crossbar select width.
    localparam int unsigned NPORTS = 5;
    localparam int unsigned SELW   = 3;

    // Per-output flit counter width; only used when ALLOC_STATS_EN is defined.
    localparam int unsigned CNTW = 16;

    // Crossbar select value meaning "no source drives this output".
    localparam logic [SELW-1:0] NO_SRC = 3'd7;

    // Port indices; N has highest pre-select priority, L the lowest.
    typedef enum logic [SELW-1:0] {
        PortN = 3'd0,
        PortE = 3'd1,
        PortW = 3'd2,
        PortS = 3'd3,
        PortL = 3'd4
    } port_e;

    // One-hot head flit type codes.
    typedef enum logic [2:0] {
        FlitHeader  = 3'b001,
        FlitPayload = 3'b010,
        FlitTail    = 3'b100
    } flit_e;

    // Per-output allocation state.
    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } out_state_e;

    // Keep only the lowest set bit, i.e. the lowest-index requested output.
    function automatic logic [NPORTS-1:0] lowest_bit(input logic [NPORTS-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Router-side bundle of the switch allocator: FIFO head state and LBDR requests in,
// FIFO pops, output valids and crossbar selects out.
// master = the allocator, slave = the router datapath that feeds and consumes it.
// flit_cnt exists only when ALLOC_STATS_EN is defined.
interface switch_allocator_if;
    import switch_allocator_pkg::*;

    logic [NPORTS-1:0]        empty;
    logic [3*NPORTS-1:0]      flit_id;
    logic [NPORTS*NPORTS-1:0] req;
    logic [NPORTS-1:0]        out_ready;
    logic [NPORTS-1:0]        rd_en;
    logic [NPORTS-1:0]        out_valid;
    logic [SELW*NPORTS-1:0]   xbar_sel;
`ifdef ALLOC_STATS_EN
    logic [CNTW*NPORTS-1:0]   flit_cnt;
`endif

    modport master (
        input  empty,
        input  flit_id,
        input  req,
        input  out_ready,
        output rd_en,
        output out_valid,
`ifdef ALLOC_STATS_EN
        output flit_cnt,
`endif
        output xbar_sel
    );

    modport slave (
        output empty,
        output flit_id,
        output req,
        output out_ready,
        input  rd_en,
        input  out_valid,
`ifdef ALLOC_STATS_EN
        input  flit_cnt,
`endif
        input  xbar_sel
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one output: the search starts at ptr+1 (mod NPORTS) and the
// first requesting input wins. Purely combinational; the pointer lives in the caller.
module rr_arbiter
    import switch_allocator_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [SELW-1:0]   idx,
    output logic              vld
);

    logic [SELW:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins last.
    always_comb begin
        gnt  = '0;
        idx  = NO_SRC;
        vld  = 1'b0;
        cand = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            cand = {1'b0, ptr} + (SELW + 1)'(k);
            if (cand >= (SELW + 1)'(NPORTS)) begin
                cand = cand - (SELW + 1)'(NPORTS);
            end
            if (req[cand[SELW-1:0]]) begin
                gnt = '0;
                gnt[cand[SELW-1:0]] = 1'b1;
                idx = cand[SELW-1:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Output-port allocator for the 5-port mesh router. Each output runs an IDLE/LOCKED FSM:
// in IDLE it round-robins among eligible HEADER bidders, then holds the winner until its
// TAIL transfers (wormhole lock). FIFO pops, valids and crossbar selects are combinational.
// Optional feature: define ALLOC_STATS_EN to add per-output transferred-flit counters.
module switch_allocator
    import switch_allocator_pkg::*;
(
    input logic                clk,
    input logic                rst,
    switch_allocator_if.master bus
);

    logic [2:0]        head      [NPORTS];
    logic [NPORTS-1:0] presel    [NPORTS];
    logic [NPORTS-1:0] bid       [NPORTS];
    logic [NPORTS-1:0] locked_in;
    logic [NPORTS-1:0] eligible;

    logic [NPORTS-1:0] arb_gnt   [NPORTS];
    logic [SELW-1:0]   arb_idx   [NPORTS];
    logic              arb_vld   [NPORTS];

    out_state_e        state_q   [NPORTS];
    out_state_e        state_d   [NPORTS];
    logic [SELW-1:0]   owner_q   [NPORTS];
    logic [SELW-1:0]   owner_d   [NPORTS];
    logic [SELW-1:0]   ptr_q     [NPORTS];
    logic [SELW-1:0]   ptr_d     [NPORTS];

    logic [NPORTS-1:0]      rd_en;
    logic [NPORTS-1:0]      out_valid;
    logic [SELW*NPORTS-1:0] xbar_sel;

    // Pre-select lowest requested output per input, mark locked inputs, form per-output bids.
    always_comb begin
        locked_in = '0;
        eligible  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            head[i]   = bus.flit_id[3*i +: 3];
            presel[i] = lowest_bit(bus.req[NPORTS*i +: NPORTS]);
        end
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (state_q[o] == StLocked && owner_q[o] == SELW'(i)) begin
                    locked_in[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            eligible[i] = !bus.empty[i] && (head[i] == FlitHeader) && !locked_in[i];
        end
        for (int o = 0; o < NPORTS; o++) begin
            bid[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                bid[o][i] = eligible[i] && presel[i][o];
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .req (bid[o]),
            .ptr (ptr_q[o]),
            .gnt (arb_gnt[o]),
            .idx (arb_idx[o]),
            .vld (arb_vld[o])
        );
    end

    // Per-output next state plus the combinational grant/transfer datapath.
    always_comb begin
        rd_en     = '0;
        out_valid = '0;
        xbar_sel  = {NPORTS{NO_SRC}};
        for (int o = 0; o < NPORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            unique case (state_q[o])
                StIdle: begin
                    // Without downstream space the pointer stays put and arbitration reruns.
                    if (arb_vld[o] && bus.out_ready[o]) begin
                        xbar_sel[SELW*o +: SELW] = arb_idx[o];
                        out_valid[o]             = 1'b1;
                        rd_en                    = rd_en | arb_gnt[o];
                        state_d[o]               = StLocked;
                        owner_d[o]               = arb_idx[o];
                        ptr_d[o]                 = arb_idx[o];
                    end
                end
                StLocked: begin
                    xbar_sel[SELW*o +: SELW] = owner_q[o];
                    if (!bus.empty[owner_q[o]] && bus.out_ready[o]) begin
                        rd_en[owner_q[o]] = 1'b1;
                        out_valid[o]      = 1'b1;
                        if (head[owner_q[o]] == FlitTail) begin
                            state_d[o] = StIdle;
                            owner_d[o] = NO_SRC;
                        end
                    end
                end
                default: begin
                    state_d[o] = StIdle;
                    owner_d[o] = NO_SRC;
                end
            endcase
        end
        // Reset must silence the datapath immediately, not only after the state clears.
        if (!rst) begin
            rd_en     = '0;
            out_valid = '0;
            xbar_sel  = {NPORTS{NO_SRC}};
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= StIdle;
                owner_q[o] <= NO_SRC;
                ptr_q[o]   <= PortL;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.out_valid = out_valid;
    assign bus.xbar_sel  = xbar_sel;

`ifdef ALLOC_STATS_EN
    logic [CNTW-1:0] cnt_q [NPORTS];

    // Count every transferred flit per output; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                cnt_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (out_valid[o]) begin
                    cnt_q[o] <= cnt_q[o] + 1'b1;
                end
            end
        end
    end

    // Flatten counters onto the bus.
    always_comb begin
        bus.flit_cnt = '0;
        for (int o = 0; o < NPORTS; o++) begin
            bus.flit_cnt[CNTW*o +: CNTW] = cnt_q[o];
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: inputs change just after the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam logic [2:0] H = FlitHeader;
    localparam logic [2:0] P = FlitPayload;
    localparam logic [2:0] T = FlitTail;
    localparam logic [2:0] Z = 3'b000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    switch_allocator_if bus ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [14:0] fids(input logic [2:0] f0, input logic [2:0] f1,
                                         input logic [2:0] f2, input logic [2:0] f3,
                                         input logic [2:0] f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    task automatic drive(input logic [4:0] emp, input logic [14:0] fid,
                         input logic [24:0] rq, input logic [4:0] rdy);
        @(negedge clk);
        bus.empty     = emp;
        bus.flit_id   = fid;
        bus.req       = rq;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        // Eligible header for N while reset is held: nothing may be granted.
        drive(5'b11110, fids(H, Z, Z, Z, Z), 25'd1, 5'b11111);
        total++;
        if (bus.rd_en !== 5'b0) begin
            bad++; $display("FAIL rst_hold_rd_en got=%b want=%b", bus.rd_en, 5'b0);
        end
        total++;
        if (bus.out_valid !== 5'b0) begin
            bad++; $display("FAIL rst_hold_out_valid got=%b want=%b", bus.out_valid, 5'b0);
        end
        total++;
        if (bus.xbar_sel !== 15'h7FFF) begin
            bad++; $display("FAIL rst_hold_xbar_sel got=%h want=%h", bus.xbar_sel, 15'h7FFF);
        end
`ifdef ALLOC_STATS_EN
        total++;
        if (bus.flit_cnt !== '0) begin
            bad++; $display("FAIL rst_hold_flit_cnt got=%h want=0", bus.flit_cnt);
        end
`endif
        @(negedge clk);
        bus.empty = 5'b11111;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(5'b11111, 15'd0, 25'd0, 5'b11111);
            total++;
            if (bus.rd_en !== 5'b0) begin
                bad++; $display("FAIL reset_rd_en cyc=%0d got=%b want=%b", c, bus.rd_en, 5'b0);
            end
            total++;
            if (bus.out_valid !== 5'b0) begin
                bad++;
                $display("FAIL reset_out_valid cyc=%0d got=%b want=%b", c, bus.out_valid, 5'b0);
            end
            total++;
            if (bus.xbar_sel !== 15'h7FFF) begin
                bad++;
                $display("FAIL reset_xbar_sel cyc=%0d got=%h want=%h", c, bus.xbar_sel, 15'h7FFF);
            end
        end
    endtask

    // Input L sends H,P,T to E; then E must go idle.
    task automatic test_single_packet();
        logic [14:0] fid [4] = '{fids(Z, Z, Z, Z, H), fids(Z, Z, Z, Z, P),
                                 fids(Z, Z, Z, Z, T), 15'd0};
        logic [4:0]  emp [4] = '{5'b01111, 5'b01111, 5'b01111, 5'b11111};
        logic [4:0]  erd [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b00000};
        logic [4:0]  eov [4] = '{5'b00010, 5'b00010, 5'b00010, 5'b00000};
        logic [14:0] esl [4] = '{15'h7FE7, 15'h7FE7, 15'h7FE7, 15'h7FFF};
        logic [24:0] rq;
        for (int c = 0; c < 4; c++) begin
            rq = '0;
            if (c == 0) rq[5*PortL + PortE] = 1'b1;
            drive(emp[c], fid[c], rq, 5'b11111);
            total++;
            if (bus.rd_en !== erd[c]) begin
                bad++; $display("FAIL single_rd_en cyc=%0d got=%b want=%b", c, bus.rd_en, erd[c]);
            end
            total++;
            if (bus.out_valid !== eov[c]) begin
                bad++;
                $display("FAIL single_out_valid cyc=%0d got=%b want=%b", c, bus.out_valid, eov[c]);
            end
            total++;
            if (bus.xbar_sel !== esl[c]) begin
                bad++;
                $display("FAIL single_xbar_sel cyc=%0d got=%h want=%h", c, bus.xbar_sel, esl[c]);
            end
        end
    endtask

    // Inputs 0,2,3 backlogged with 2-flit packets to L: owners 0,0,2,2,3,3,0,0.
    task automatic test_round_robin();
        int          owner [8] = '{0, 0, 2, 2, 3, 3, 0, 0};
        logic        phase [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f [5];
        logic [24:0] rq;
        logic [4:0]  exp_rd;
        logic [14:0] exp_sl;
        rq = '0;
        rq[4] = 1'b1;
        rq[14] = 1'b1;
        rq[19] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 5; i++) f[i] = (i == 1 || i == 4) ? Z : (phase[i] ? T : H);
            drive(5'b10010, fids(f[0], f[1], f[2], f[3], f[4]), rq, 5'b11111);
            exp_rd = 5'b00001 << owner[c];
            exp_sl = {3'(owner[c]), 12'hFFF};
            total++;
            if (bus.rd_en !== exp_rd) begin
                bad++; $display("FAIL rr_rd_en cyc=%0d got=%b want=%b", c, bus.rd_en, exp_rd);
            end
            total++;
            if (bus.out_valid !== 5'b10000) begin
                bad++;
                $display("FAIL rr_out_valid cyc=%0d got=%b want=%b", c, bus.out_valid, 5'b10000);
            end
            total++;
            if (bus.xbar_sel !== exp_sl) begin
                bad++; $display("FAIL rr_xbar_sel cyc=%0d got=%h want=%h", c, bus.xbar_sel, exp_sl);
            end
            phase[owner[c]] = ~phase[owner[c]];
        end
        drive(5'b11111, 15'd0, 25'd0, 5'b11111);
    endtask

    // Input 2 locked on E, 3 stalled cycles; input 3 header to E waits for the tail.
    task automatic test_backpressure();
        logic [4:0]  emp [9] = '{5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011,
                                 5'b10011, 5'b10111, 5'b10111, 5'b11111};
        logic [2:0]  f2  [9] = '{H, P, P, P, P, T, Z, Z, Z};
        logic [2:0]  f3  [9] = '{H, H, H, H, H, H, H, T, Z};
        logic [4:0]  rdy [9] = '{5'b11111, 5'b11101, 5'b11101, 5'b11101, 5'b11111,
                                 5'b11111, 5'b11111, 5'b11111, 5'b11111};
        logic [4:0]  erd [9] = '{5'b00100, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b00100,
                                 5'b01000, 5'b01000, 5'b0};
        logic [4:0]  eov [9] = '{5'b00010, 5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010,
                                 5'b00010, 5'b00010, 5'b0};
        logic [14:0] esl [9] = '{15'h7FD7, 15'h7FD7, 15'h7FD7, 15'h7FD7, 15'h7FD7,
                                 15'h7FD7, 15'h7FDF, 15'h7FDF, 15'h7FFF};
        logic [24:0] rq;
        rq = '0;
        rq[5*2 + 1] = 1'b1;
        rq[5*3 + 1] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive(emp[c], fids(Z, Z, f2[c], f3[c], Z), rq, rdy[c]);
            total++;
            if (bus.rd_en !== erd[c]) begin
                bad++; $display("FAIL bp_rd_en cyc=%0d got=%b want=%b", c, bus.rd_en, erd[c]);
            end
            total++;
            if (bus.out_valid !== eov[c]) begin
                bad++;
                $display("FAIL bp_out_valid cyc=%0d got=%b want=%b", c, bus.out_valid, eov[c]);
            end
            total++;
            if (bus.xbar_sel !== esl[c]) begin
                bad++; $display("FAIL bp_xbar_sel cyc=%0d got=%h want=%h", c, bus.xbar_sel, esl[c]);
            end
        end
    endtask

    // Input 1 requests N and S: only N taken; input 3 gets S in the same cycle.
    task automatic test_preselect();
        logic [4:0]  emp [3] = '{5'b10101, 5'b10101, 5'b11111};
        logic [14:0] fid [3] = '{fids(Z, H, Z, H, Z), fids(Z, T, Z, T, Z), 15'd0};
        logic [4:0]  erd [3] = '{5'b01010, 5'b01010, 5'b0};
        logic [4:0]  eov [3] = '{5'b01001, 5'b01001, 5'b0};
        logic [14:0] esl [3] = '{15'h77F9, 15'h77F9, 15'h7FFF};
        logic [24:0] rq;
        rq = '0;
        rq[5*PortE + PortN] = 1'b1;
        rq[5*PortE + PortS] = 1'b1;
        rq[5*PortS + PortS] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(emp[c], fid[c], rq, 5'b11111);
            total++;
            if (bus.rd_en !== erd[c]) begin
                bad++; $display("FAIL presel_rd_en cyc=%0d got=%b want=%b", c, bus.rd_en, erd[c]);
            end
            total++;
            if (bus.out_valid !== eov[c]) begin
                bad++;
                $display("FAIL presel_out_valid cyc=%0d got=%b want=%b", c, bus.out_valid, eov[c]);
            end
            total++;
            if (bus.xbar_sel !== esl[c]) begin
                bad++;
                $display("FAIL presel_xbar_sel cyc=%0d got=%h want=%h", c, bus.xbar_sel, esl[c]);
            end
        end
    endtask

    // W locked to input 0, reset mid-packet; afterwards 0 beats 2 because the pointer is 4.
    task automatic test_reset_mid_packet();
        logic [24:0] rq;
        rq = '0;
        rq[5*0 + PortW] = 1'b1;
        drive(5'b11110, fids(H, Z, Z, Z, Z), rq, 5'b11111);
        total++;
        if (bus.xbar_sel !== 15'h7E3F) begin
            bad++; $display("FAIL mid_grant_xbar_sel got=%h want=%h", bus.xbar_sel, 15'h7E3F);
        end
        drive(5'b11110, fids(P, Z, Z, Z, Z), rq, 5'b11111);
        total++;
        if (bus.rd_en !== 5'b00001) begin
            bad++; $display("FAIL mid_payload_rd_en got=%b want=%b", bus.rd_en, 5'b00001);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.xbar_sel !== 15'h7FFF) begin
            bad++; $display("FAIL mid_async_xbar_sel got=%h want=%h", bus.xbar_sel, 15'h7FFF);
        end
        total++;
        if (bus.rd_en !== 5'b0 || bus.out_valid !== 5'b0) begin
            bad++;
            $display("FAIL mid_async_rd_valid got=%b/%b want=00000/00000", bus.rd_en, bus.out_valid);
        end
`ifdef ALLOC_STATS_EN
        total++;
        if (bus.flit_cnt !== '0) begin
            bad++; $display("FAIL mid_async_flit_cnt got=%h want=0", bus.flit_cnt);
        end
`endif
        @(negedge clk);
        bus.empty = 5'b11111;
        rst = 1'b1;
        drive(5'b11111, 15'd0, 25'd0, 5'b11111);
        total++;
        if (bus.xbar_sel !== 15'h7FFF) begin
            bad++; $display("FAIL post_rst_idle_xbar_sel got=%h want=%h", bus.xbar_sel, 15'h7FFF);
        end
        rq[5*2 + PortW] = 1'b1;
        drive(5'b11010, fids(H, Z, H, Z, Z), rq, 5'b11111);
        total++;
        if (bus.rd_en !== 5'b00001) begin
            bad++; $display("FAIL post_rst_rd_en got=%b want=%b", bus.rd_en, 5'b00001);
        end
        total++;
        if (bus.xbar_sel !== 15'h7E3F) begin
            bad++; $display("FAIL post_rst_xbar_sel got=%h want=%h", bus.xbar_sel, 15'h7E3F);
        end
        total++;
        if (bus.out_valid !== 5'b00100) begin
            bad++; $display("FAIL post_rst_out_valid got=%b want=%b", bus.out_valid, 5'b00100);
        end
`ifdef ALLOC_STATS_EN
        drive(5'b11011, fids(Z, Z, H, Z, Z), 25'd0, 5'b11111);
        total++;
        if (bus.flit_cnt[CNTW*PortW +: CNTW] !== CNTW'(1)) begin
            bad++;
            $display("FAIL post_rst_flit_cnt got=%0d want=1", bus.flit_cnt[CNTW*PortW +: CNTW]);
        end
`endif
    endtask

    initial begin
        bus.empty     = 5'b11111;
        bus.flit_id   = '0;
        bus.req       = '0;
        bus.out_ready = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_preselect();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
